johnson_phase_monitor: RTL
==========================

JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

Interface
REQ-001 Parameter: LOCK_N, default 3, consecutive legal transitions required to declare lock (range 1..7).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: clear  input  1  reset, asynchronous, active-low.
REQ-004 Port: cnt_in  input  4  code from upstream 4-bit twisted-ring counter, bit 3 = MSB.
REQ-005 Port: cnt_valid  input  1  cnt_in is sampled only on edges where this is 1.
REQ-006 Port: phase  output  3  decoded phase index of last legal sample.
REQ-007 Port: phase_oh  output  8  one-hot of phase; all-zero when no legal sample held.
REQ-008 Port: locked  output  1  high while FSM is in LOCKED.
REQ-009 Port: err_code  output  1  one-cycle pulse: sampled code is illegal.
REQ-010 Port: err_seq  output  1  one-cycle pulse: legal code but not the successor of the previous legal code.
REQ-011 Port: err_count  output  8  count of samples flagged err_code or err_seq, saturating at 255.
REQ-012 Port: cycle_pulse  output  1  one-cycle pulse on wrap phase 7 -> 0 while LOCKED.
REQ-013 Port: cycle_count  output  8  count of cycle_pulse events, wraps 255 -> 0.

Function
REQ-014 Legal map (cnt_in -> phase) SHALL be 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7; all other 8 codes illegal.
REQ-015 Legal successor SHALL be phase+1 mod 8; a repeated code on consecutive valid samples is err_seq.
REQ-016 All outputs SHALL be registered; response appears on the edge that samples cnt_in (1-cycle latency from input change).
REQ-017 With cnt_valid=0: no state change, pulses deassert, phase/phase_oh/counters hold.
REQ-018 Illegal sample: err_code=1, phase/phase_oh hold previous value, stored previous-code marked invalid.
REQ-019 First legal sample after reset, FAULT, or an illegal sample: no err_seq check; it only seeds phase.
REQ-020 FSM states: UNLOCKED, LOCKED, FAULT; reset state UNLOCKED.
REQ-021 UNLOCKED: internal good-transition counter increments per legal successor, clears on any error; at LOCK_N -> LOCKED.
REQ-022 LOCKED: any err_code or err_seq -> FAULT on same edge; locked drops that edge.
REQ-023 FAULT: next legal sample -> UNLOCKED with good counter 0; illegal samples stay in FAULT.
REQ-024 err_code and err_seq SHALL never assert together.
REQ-025 err_count increments by 1 per flagged sample, holds at 255.
REQ-026 cycle_pulse only for a legal 7->0 transition while state is LOCKED before the edge; the transition that causes lock does not pulse.

Reset
REQ-027 clear=0 SHALL immediately force phase=0, phase_oh=0x00, locked=0, err_code=0, err_seq=0, err_count=0, cycle_pulse=0, cycle_count=0, state UNLOCKED, good counter 0, previous-code invalid.
REQ-028 Reset mid-operation SHALL discard all history; first valid sample after release behaves per REQ-019.
REQ-029 Release of clear SHALL not itself generate any pulse.

Verification
REQ-030 Reset then feed 0,8,12,14,15,7,3,1,0 each cycle, valid=1, LOCK_N=3 -> locked=1 after sample 14 (4th sample), cycle_pulse once at final 0, cycle_count=1, err_count=0.
REQ-031 While locked, inject cnt_in=0101 -> err_code=1 one cycle, locked=0, state FAULT, err_count=1, phase holds; next 0011 -> UNLOCKED, phase=6, no err_seq.
REQ-032 While locked at phase 2 (1100), feed 1111 -> err_seq=1, err_code=0, locked=0, phase=4.
REQ-033 Valid=0 for 5 cycles with cnt_in toggling randomly -> all outputs unchanged, no pulses; resume with correct successor -> no error.
REQ-034 Force 260 illegal samples -> err_count saturates at 255; run 256 locked full cycles -> cycle_count returns to 0.
REQ-035 Assert clear while locked mid-cycle at phase 5 -> all outputs to reset values asynchronously before next clk edge.

Source files
------------

// File: rtl/johnson_phase_monitor.sv
// Monitors a 4-bit twisted-ring counter: decodes its phase, flags illegal codes and
// out-of-order steps, and declares lock after LOCK_N consecutive legal successors.
module johnson_phase_monitor #(
  parameter int unsigned LOCK_N = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] cnt_in,
  input  logic       cnt_valid,
  output logic [2:0] phase,
  output logic [7:0] phase_oh,
  output logic       locked,
  output logic       err_code,
  output logic       err_seq,
  output logic [7:0] err_count,
  output logic       cycle_pulse,
  output logic [7:0] cycle_count
);

  typedef enum logic [1:0] {StUnlocked, StLocked, StFault} state_e;

  localparam logic [2:0] LockTarget = 3'(LOCK_N);

  state_e     state_q, state_d;
  logic [2:0] good_q, good_d;
  logic       prev_valid_q, prev_valid_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] phase_oh_q, phase_oh_d;
  logic       err_code_q, err_code_d;
  logic       err_seq_q, err_seq_d;
  logic [7:0] err_count_q, err_count_d;
  logic       cycle_pulse_q, cycle_pulse_d;
  logic [7:0] cycle_count_q, cycle_count_d;

  logic       code_legal;
  logic [2:0] code_idx;
  logic [2:0] good_inc;

  always_comb begin
    code_legal = 1'b1;
    code_idx   = 3'd0;
    case (cnt_in)
      4'b0000: code_idx = 3'd0;
      4'b1000: code_idx = 3'd1;
      4'b1100: code_idx = 3'd2;
      4'b1110: code_idx = 3'd3;
      4'b1111: code_idx = 3'd4;
      4'b0111: code_idx = 3'd5;
      4'b0011: code_idx = 3'd6;
      4'b0001: code_idx = 3'd7;
      default: code_legal = 1'b0;
    endcase
  end

  assign good_inc = good_q + 3'd1;

  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    prev_valid_d  = prev_valid_q;
    phase_d       = phase_q;
    phase_oh_d    = phase_oh_q;
    err_code_d    = 1'b0;
    err_seq_d     = 1'b0;
    err_count_d   = err_count_q;
    cycle_pulse_d = 1'b0;
    cycle_count_d = cycle_count_q;

    if (cnt_valid) begin
      if (!code_legal) begin
        err_code_d   = 1'b1;
        prev_valid_d = 1'b0;
        good_d       = 3'd0;
        if (state_q == StLocked) state_d = StFault;
      end else begin
        phase_d      = code_idx;
        phase_oh_d   = 8'd1 << code_idx;
        prev_valid_d = 1'b1;
        if (!prev_valid_q || state_q == StFault) begin
          // Seeding sample: no sequence check, just re-arm from a clean good count.
          good_d = 3'd0;
          if (state_q == StFault) state_d = StUnlocked;
        end else if (code_idx == phase_q + 3'd1) begin
          if (state_q == StLocked && phase_q == 3'd7) begin
            cycle_pulse_d = 1'b1;
            cycle_count_d = cycle_count_q + 8'd1;
          end
          if (state_q == StUnlocked) begin
            if (good_inc >= LockTarget) begin
              state_d = StLocked;
              good_d  = 3'd0;
            end else begin
              good_d = good_inc;
            end
          end
        end else begin
          err_seq_d = 1'b1;
          good_d    = 3'd0;
          if (state_q == StLocked) state_d = StFault;
        end
      end
      if ((err_code_d || err_seq_d) && err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q       <= StUnlocked;
      good_q        <= 3'd0;
      prev_valid_q  <= 1'b0;
      phase_q       <= 3'd0;
      phase_oh_q    <= 8'h00;
      err_code_q    <= 1'b0;
      err_seq_q     <= 1'b0;
      err_count_q   <= 8'd0;
      cycle_pulse_q <= 1'b0;
      cycle_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      prev_valid_q  <= prev_valid_d;
      phase_q       <= phase_d;
      phase_oh_q    <= phase_oh_d;
      err_code_q    <= err_code_d;
      err_seq_q     <= err_seq_d;
      err_count_q   <= err_count_d;
      cycle_pulse_q <= cycle_pulse_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign phase       = phase_q;
  assign phase_oh    = phase_oh_q;
  assign locked      = (state_q == StLocked);
  assign err_code    = err_code_q;
  assign err_seq     = err_seq_q;
  assign err_count   = err_count_q;
  assign cycle_pulse = cycle_pulse_q;
  assign cycle_count = cycle_count_q;

endmodule
